// File: rtl/dcbarb_pkg.sv
// dcbarb_pkg
// Shared definitions for the DCB arbitration request-side logic.
//   DCBARB_N         default number of requesters
//   DCBARB_HOLD_MAX  default maximum consecutive grants to a locked owner
//   DCBARB_OH_W      widest one-hot vector onehot2idx accepts
//   dcbarb_st_e      arbiter state encoding
//   onehot2idx       one-hot to binary index conversion (0 for an all-zero vector)
package dcbarb_pkg;

  localparam int DCBARB_N        = 8;
  localparam int DCBARB_HOLD_MAX = 4;
  localparam int DCBARB_OH_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } dcbarb_st_e;

  // OR of the indices of all set bits; exact for one-hot and all-zero inputs.
  function automatic logic [7:0] onehot2idx(input logic [DCBARB_OH_W-1:0] oh);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < DCBARB_OH_W; i++) begin
      if (oh[i]) idx = idx | 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dcbarb_rr_pick.sv
// dcbarb_rr_pick
// Combinational round-robin winner search.
//   req         in   N      request vector
//   ptr         in   IDX_W  index of the last granted requester
//   winner      out  N      one-hot winner (all-zero when no request)
//   winner_idx  out  IDX_W  binary index of winner (0 when no request)
//   any         out  1      at least one request present
// The request vector is duplicated side by side and only the N positions
// ptr+1 .. ptr+N are eligible, so a plain lowest-bit-first scan over the
// doubled vector yields the round-robin order without any rotate logic.
module dcbarb_rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] win_mask;
  logic [2*N-1:0] hit;
  logic [31:0]    ptr_ext;

  assign req_dbl = {req, req};
  assign ptr_ext = 32'(ptr);

  for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
    assign win_mask[gi] = (32'(gi) > ptr_ext) && (32'(gi) <= ptr_ext + 32'(N));
  end

  assign hit = req_dbl & win_mask;

  // Scan from the top down so the lowest eligible position is the last to write.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (hit[i]) begin
        any        = 1'b1;
        winner_idx = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
      end
    end
    if (any) winner[winner_idx] = 1'b1;
  end

endmodule

// File: rtl/dcbarb_rr_grant_gen.sv
// dcbarb_rr_grant_gen
// Registered round-robin grant generator with bounded burst lock and stall.
//   clk        in   1      clock
//   rst_n      in   1      asynchronous reset, active-low
//   req        in   N      per-requester request (level)
//   lock       in   N      per-requester burst-lock hint, qualified by req
//   stall      in   1      downstream not ready; freezes grant and arbiter state
//   grant      out  N      registered one-hot grant (all-zero = none)
//   grant_vld  out  1      registered |grant
//   grant_idx  out  IDX_W  registered binary index of grant (0 when none)
//   hold_cnt   out  3      consecutive-grant count of the current owner
//   err        out  1      sticky: grant was seen with more than one bit set
module dcbarb_rr_grant_gen
  import dcbarb_pkg::*;
#(
  parameter  int N        = DCBARB_N,
  parameter  int HOLD_MAX = DCBARB_HOLD_MAX,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     lock,
  input  logic             stall,
  output logic [N-1:0]     grant,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx,
  output logic [2:0]       hold_cnt,
  output logic             err
);

  dcbarb_st_e       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             grant_vld_q, grant_vld_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [2:0]       hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [N-1:0]     rr_winner;
  logic [IDX_W-1:0] rr_winner_idx;
  logic             rr_any;
  logic             owner_locked;
  logic             grant_multi;

  dcbarb_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (rr_winner),
    .winner_idx (rr_winner_idx),
    .any        (rr_any)
  );

  assign owner_locked = req[grant_idx_q] & lock[grant_idx_q];
  assign grant_multi  = (grant_q & (grant_q - {{(N-1){1'b0}}, 1'b1})) != '0;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;

    if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (rr_any) begin
            state_d    = GRANT;
            grant_d    = rr_winner;
            hold_cnt_d = 3'd1;
            ptr_d      = rr_winner_idx;
          end
        end
        GRANT, HOLD: begin
          if (owner_locked && (hold_cnt_q < 3'(HOLD_MAX))) begin
            state_d    = HOLD;
            hold_cnt_d = hold_cnt_q + 3'd1;
          end else if (rr_any) begin
            // Search starts after the owner, so it only wins again when alone.
            state_d    = GRANT;
            grant_d    = rr_winner;
            hold_cnt_d = 3'd1;
            ptr_d      = rr_winner_idx;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            hold_cnt_d = 3'd0;
          end
        end
        default: begin
          state_d    = IDLE;
          grant_d    = '0;
          hold_cnt_d = 3'd0;
        end
      endcase
    end

    grant_vld_d = |grant_d;
    grant_idx_d = IDX_W'(onehot2idx(DCBARB_OH_W'(grant_d)));
    err_d       = err_q | grant_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      grant_idx_q <= '0;
      hold_cnt_q  <= 3'd0;
      ptr_q       <= IDX_W'(N - 1);
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = grant_vld_q;
  assign grant_idx = grant_idx_q;
  assign hold_cnt  = hold_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dcbarb_rr_grant_gen.sv
// tb_dcbarb_rr_grant_gen
// Directed scenarios for the round-robin grant generator (N=8, HOLD_MAX=4).
// Each scenario task drives inputs and compares the packed output tuple
// {grant, grant_vld, grant_idx, hold_cnt} against hand-computed values.
module tb_dcbarb_rr_grant_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] lock;
  logic       stall;
  logic [7:0] grant;
  logic       grant_vld;
  logic [2:0] grant_idx;
  logic [2:0] hold_cnt;
  logic       err;

  int assertions_cnt = 0;
  int failures_cnt   = 0;
  bit run_done       = 1'b0;

  dcbarb_rr_grant_gen #(
    .N        (8),
    .HOLD_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .stall     (stall),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .hold_cnt  (hold_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants checked every cycle on the falling edge.
  always @(negedge clk) begin
    if (!run_done) begin
      assertions_cnt++;
      if (!$onehot0(grant) || (grant_vld !== (|grant)) || (err !== 1'b0)) begin
        failures_cnt++;
        $display("FAIL invariant t=%0t grant=%h grant_vld=%b err=%b (need onehot0, vld=|grant, err=0)",
                 $time, grant, grant_vld, err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; lock = 8'h00; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions_cnt++;
      if ({grant, grant_vld, grant_idx, hold_cnt, err} !== 16'h0000) begin
        failures_cnt++;
        $display("FAIL reset_hold cyc=%0d got g=%h v=%b i=%0d h=%0d e=%b need all zero",
                 i, grant, grant_vld, grant_idx, hold_cnt, err);
      end
      $display("reset cyc=%0d g=%h v=%b i=%0d h=%0d", i, grant, grant_vld, grant_idx, hold_cnt);
    end
    req   = 8'h00;
    rst_n = 1'b1;
    tick();
    assertions_cnt++;
    if ({grant, grant_vld, grant_idx, hold_cnt} !== 15'h0000) begin
      failures_cnt++;
      $display("FAIL reset_idle got g=%h v=%b i=%0d h=%0d need all zero",
               grant, grant_vld, grant_idx, hold_cnt);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] eg;
    logic [2:0] ei;
    req = 8'hFF; lock = 8'h00; stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      eg = 8'h01 << (i % 8);
      ei = 3'(i % 8);
      assertions_cnt++;
      if ({grant, grant_vld, grant_idx, hold_cnt} !== {eg, 1'b1, ei, 3'd1}) begin
        failures_cnt++;
        $display("FAIL rotation step=%0d got g=%h i=%0d h=%0d need g=%h i=%0d h=1",
                 i, grant, grant_idx, hold_cnt, eg, ei);
      end
      $display("rotation step=%0d g=%h i=%0d", i, grant, grant_idx);
    end
  endtask

  task automatic test_wrap_skip();
    logic [7:0] tg [3] = '{8'h80, 8'h01, 8'h80};
    logic [2:0] ti [3] = '{3'd7, 3'd0, 3'd7};
    req = 8'h01;
    tick();
    assertions_cnt++;
    if ({grant, grant_idx} !== {8'h01, 3'd0}) begin
      failures_cnt++;
      $display("FAIL wrap_setup got g=%h i=%0d need g=01 i=0", grant, grant_idx);
    end
    req = 8'h81;
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions_cnt++;
      if ({grant, grant_vld, grant_idx, hold_cnt} !== {tg[i], 1'b1, ti[i], 3'd1}) begin
        failures_cnt++;
        $display("FAIL wrap_skip step=%0d got g=%h i=%0d h=%0d need g=%h i=%0d h=1",
                 i, grant, grant_idx, hold_cnt, tg[i], ti[i]);
      end
      $display("wrap_skip step=%0d g=%h i=%0d", i, grant, grant_idx);
    end
    req = 8'h00;
    tick();
    assertions_cnt++;
    if ({grant, grant_vld, grant_idx, hold_cnt} !== 15'h0000) begin
      failures_cnt++;
      $display("FAIL wrap_idle got g=%h v=%b i=%0d h=%0d need all zero",
               grant, grant_vld, grant_idx, hold_cnt);
    end
  endtask

  task automatic test_lock();
    logic [7:0] tg [6] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h02};
    logic [2:0] ti [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd1};
    logic [2:0] th [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd1};
    req = 8'h06; lock = 8'h02;
    for (int i = 0; i < 6; i++) begin
      tick();
      assertions_cnt++;
      if ({grant, grant_vld, grant_idx, hold_cnt} !== {tg[i], 1'b1, ti[i], th[i]}) begin
        failures_cnt++;
        $display("FAIL lock step=%0d got g=%h i=%0d h=%0d need g=%h i=%0d h=%0d",
                 i, grant, grant_idx, hold_cnt, tg[i], ti[i], th[i]);
      end
      $display("lock step=%0d g=%h i=%0d h=%0d", i, grant, grant_idx, hold_cnt);
    end
  endtask

  task automatic test_stall();
    lock = 8'h00;
    tick();
    assertions_cnt++;
    if ({grant, grant_idx, hold_cnt} !== {8'h04, 3'd2, 3'd1}) begin
      failures_cnt++;
      $display("FAIL stall_setup got g=%h i=%0d h=%0d need g=04 i=2 h=1", grant, grant_idx, hold_cnt);
    end
    stall = 1'b1; req = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions_cnt++;
      if ({grant, grant_vld, grant_idx, hold_cnt} !== {8'h04, 1'b1, 3'd2, 3'd1}) begin
        failures_cnt++;
        $display("FAIL stall_freeze cyc=%0d got g=%h i=%0d h=%0d need g=04 i=2 h=1",
                 i, grant, grant_idx, hold_cnt);
      end
      $display("stall cyc=%0d g=%h i=%0d", i, grant, grant_idx);
    end
    stall = 1'b0;
    tick();
    assertions_cnt++;
    if ({grant, grant_vld, grant_idx, hold_cnt} !== {8'h10, 1'b1, 3'd4, 3'd1}) begin
      failures_cnt++;
      $display("FAIL stall_release got g=%h i=%0d h=%0d need g=10 i=4 h=1", grant, grant_idx, hold_cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    req = 8'h20; lock = 8'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions_cnt++;
      if ({grant, grant_idx, hold_cnt} !== {8'h20, 3'd5, 3'(i + 1)}) begin
        failures_cnt++;
        $display("FAIL hold_build step=%0d got g=%h i=%0d h=%0d need g=20 i=5 h=%0d",
                 i, grant, grant_idx, hold_cnt, i + 1);
      end
    end
    rst_n = 1'b0;
    #2;
    assertions_cnt++;
    if ({grant, grant_vld, grant_idx, hold_cnt, err} !== 16'h0000) begin
      failures_cnt++;
      $display("FAIL async_reset got g=%h v=%b i=%0d h=%0d need all zero",
               grant, grant_vld, grant_idx, hold_cnt);
    end
    tick();
    req = 8'h21; lock = 8'h00;
    rst_n = 1'b1;
    tick();
    assertions_cnt++;
    if ({grant, grant_vld, grant_idx, hold_cnt} !== {8'h01, 1'b1, 3'd0, 3'd1}) begin
      failures_cnt++;
      $display("FAIL post_reset_grant got g=%h i=%0d h=%0d need g=01 i=0 h=1", grant, grant_idx, hold_cnt);
    end
    $display("post_reset g=%h i=%0d", grant, grant_idx);
  endtask

  task automatic test_sole_lock();
    logic [2:0] th [5] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd2};
    req = 8'h01; lock = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      assertions_cnt++;
      if ({grant, grant_vld, grant_idx, hold_cnt} !== {8'h01, 1'b1, 3'd0, th[i]}) begin
        failures_cnt++;
        $display("FAIL sole_lock step=%0d got g=%h i=%0d h=%0d need g=01 i=0 h=%0d",
                 i, grant, grant_idx, hold_cnt, th[i]);
      end
      $display("sole_lock step=%0d g=%h h=%0d", i, grant, hold_cnt);
    end
    req = 8'h00; lock = 8'h00;
    tick();
    assertions_cnt++;
    if ({grant, grant_vld, grant_idx, hold_cnt} !== 15'h0000) begin
      failures_cnt++;
      $display("FAIL sole_idle got g=%h h=%0d need all zero", grant, hold_cnt);
    end
  endtask

  task automatic test_stall_idle();
    stall = 1'b1; req = 8'hFF;
    tick();
    assertions_cnt++;
    if ({grant, grant_vld, hold_cnt} !== 12'h000) begin
      failures_cnt++;
      $display("FAIL stall_idle got g=%h v=%b h=%0d need all zero", grant, grant_vld, hold_cnt);
    end
    stall = 1'b0;
    tick();
    assertions_cnt++;
    if ({grant, grant_vld, grant_idx, hold_cnt} !== {8'h02, 1'b1, 3'd1, 3'd1}) begin
      failures_cnt++;
      $display("FAIL stall_idle_release got g=%h i=%0d h=%0d need g=02 i=1 h=1",
               grant, grant_idx, hold_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_lock();
    test_stall();
    test_reset_mid_hold();
    test_sole_lock();
    test_stall_idle();
    run_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions_cnt, failures_cnt);
    $finish;
  end

endmodule
